// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - framebuffer RAM port arbiter between VGA scan-out and a drawing requester
//
// Ports:
//   reloj, resetM          pixel clock, asynchronous active-low reset
//   Qh, Qv, H_ON, V_ON     timing counter position and visible-region flags
//   H_Sync, V_Sync         syncs from the timing counter
//   wr_req/wr_addr/wr_data drawing requester write (4-phase, level request)
//   wr_ack                 one-cycle write acknowledge
//   mem_addr/mem_we/mem_wdata/mem_rdata  single-port synchronous RAM port
//   rgb_out, pix_valid     scan-out pixel and its valid flag
//   H_Sync_d, V_Sync_d     syncs delayed to line up with rgb_out
//   frame_start            one-cycle pulse at the start of each frame
module vga_fb_arbiter #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int SCALE_SHIFT = 3,
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 12
) (
  input  logic              reloj,
  input  logic              resetM,
  input  logic [9:0]        Qh,
  input  logic [9:0]        Qv,
  input  logic              H_ON,
  input  logic              V_ON,
  input  logic              H_Sync,
  input  logic              V_Sync,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rgb_out,
  output logic              pix_valid,
  output logic              H_Sync_d,
  output logic              V_Sync_d,
  output logic              frame_start
);

  // Scan-out latency is structural (address reg, RAM reg, output reg).
  localparam int PIPE_LAT = 3;
  localparam int COLS     = H_ACTIVE >> SCALE_SHIFT;
  localparam int ROWS     = V_ACTIVE >> SCALE_SHIFT;
  localparam logic [ADDR_W-1:0] COLS_V   = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] FB_WORDS = ADDR_W'(COLS * ROWS);

  typedef enum logic [1:0] {IDLE, WRITE, ACK, WAIT_LOW} state_t;

  state_t            state, state_nx;
  logic              active;
  logic [ADDR_W-1:0] row, col, scan_addr;
  logic [ADDR_W-1:0] addr_nx;
  logic [DATA_W-1:0] wdata_nx;
  logic              we_nx;
  logic [PIPE_LAT-1:0] vld_pipe, hs_pipe, vs_pipe;
  logic              at_origin, at_origin_q;

  assign active = H_ON & V_ON;
  assign row    = ADDR_W'(Qv >> SCALE_SHIFT);
  assign col    = ADDR_W'(Qh >> SCALE_SHIFT);

  // row*COLS as a sum of shifted rows, one term per set bit of COLS.
  always_comb begin
    scan_addr = col;
    for (int b = 0; b < ADDR_W; b++) begin
      if (COLS_V[b]) scan_addr = scan_addr + (row << b);
    end
  end

  always_comb begin
    state_nx = state;
    addr_nx  = mem_addr;
    wdata_nx = mem_wdata;
    we_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (wr_req && !active) begin
          state_nx = WRITE;
          addr_nx  = wr_addr;
          wdata_nx = wr_data;
          // Out-of-image addresses still complete the handshake, but never write.
          we_nx    = (wr_addr < FB_WORDS);
        end
      end
      WRITE:    state_nx = ACK;
      ACK:      state_nx = WAIT_LOW;
      WAIT_LOW: if (!wr_req) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
    // Scan reads always own the next port cycle; a write never starts on an
    // active sample, so this cannot clobber a freshly captured write.
    if (active) begin
      addr_nx = scan_addr;
      we_nx   = 1'b0;
    end
  end

  assign wr_ack    = (state == ACK);
  assign pix_valid = vld_pipe[PIPE_LAT-1];
  assign H_Sync_d  = hs_pipe[PIPE_LAT-1];
  assign V_Sync_d  = vs_pipe[PIPE_LAT-1];
  assign at_origin = (Qh == 10'd0) && (Qv == 10'd0);

  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      state       <= IDLE;
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
      vld_pipe    <= '0;
      hs_pipe     <= '0;
      vs_pipe     <= '0;
      rgb_out     <= '0;
      at_origin_q <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state     <= state_nx;
      mem_addr  <= addr_nx;
      mem_we    <= we_nx;
      mem_wdata <= wdata_nx;
      vld_pipe  <= {vld_pipe[PIPE_LAT-2:0], active};
      hs_pipe   <= {hs_pipe[PIPE_LAT-2:0], H_Sync};
      vs_pipe   <= {vs_pipe[PIPE_LAT-2:0], V_Sync};
      // RAM data for the sample two cycles back is on mem_rdata now.
      rgb_out   <= vld_pipe[PIPE_LAT-2] ? mem_rdata : '0;
      // Edge-detected so a stalled counter at the origin pulses only once.
      at_origin_q <= at_origin;
      frame_start <= at_origin & ~at_origin_q;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - directed self-checking bench for vga_fb_arbiter
module tb_vga_fb_arbiter;

  logic        reloj = 1'b0;
  logic        resetM = 1'b0;
  logic [9:0]  Qh = '0, Qv = '0;
  logic        H_ON = 1'b0, V_ON = 1'b0, H_Sync = 1'b0, V_Sync = 1'b0;
  logic        wr_req = 1'b0;
  logic [12:0] wr_addr = '0;
  logic [11:0] wr_data = '0;
  logic        wr_ack;
  logic [12:0] mem_addr;
  logic        mem_we;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;
  logic [11:0] rgb_out;
  logic        pix_valid, H_Sync_d, V_Sync_d, frame_start;

  vga_fb_arbiter dut (
    .reloj(reloj), .resetM(resetM), .Qh(Qh), .Qv(Qv), .H_ON(H_ON), .V_ON(V_ON),
    .H_Sync(H_Sync), .V_Sync(V_Sync), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ack(wr_ack), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .rgb_out(rgb_out),
    .pix_valid(pix_valid), .H_Sync_d(H_Sync_d), .V_Sync_d(V_Sync_d),
    .frame_start(frame_start)
  );

  always #5 reloj = ~reloj;

  // Framebuffer RAM: read-first, one-cycle read latency, preloaded with data=address.
  logic [11:0] ram [0:8191];
  bit loaded = 1'b0;
  always @(posedge reloj) begin
    if (!loaded) begin
      for (int i = 0; i < 8192; i++) ram[i] <= 12'(i);
      loaded <= 1'b1;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  int n_assert = 0;
  int n_fail   = 0;
  int exp_mem [8192];
  int hh [4], hv [4];
  bit hk [4], hval [4], hhs [4], hvs [4], hfs [4];
  bit prev_at0 = 1'b0;
  bit stream_chk = 1'b0;
  int fs_count = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int addr_of(input int h, input int v);
    return (v / 8) * 80 + (h / 8);
  endfunction

  task automatic clear_hist();
    for (int i = 0; i < 4; i++) hk[i] = 1'b0;
    prev_at0 = 1'b0;
  endtask

  // Present one counter sample (standard 800x525 timing) and record expectations.
  task automatic drive(input int h, input int v);
    Qh     = 10'(h);
    Qv     = 10'(v);
    H_ON   = (h < 640);
    V_ON   = (v < 480);
    H_Sync = (h >= 656) && (h < 752);
    V_Sync = (v >= 490) && (v < 492);
    hk[0]   = 1'b1;
    hh[0]   = h;
    hv[0]   = v;
    hval[0] = (h < 640) && (v < 480);
    hhs[0]  = H_Sync;
    hvs[0]  = V_Sync;
    hfs[0]  = (h == 0) && (v == 0) && !prev_at0;
    prev_at0 = (h == 0) && (v == 0);
  endtask

  // Advance one cycle; check address one cycle and outputs three cycles after each sample.
  task automatic step();
    @(negedge reloj);
    for (int i = 3; i > 0; i--) begin
      hk[i] = hk[i-1]; hh[i] = hh[i-1]; hv[i] = hv[i-1];
      hval[i] = hval[i-1]; hhs[i] = hhs[i-1]; hvs[i] = hvs[i-1]; hfs[i] = hfs[i-1];
    end
    hk[0] = 1'b0;
    if (frame_start === 1'b1) fs_count++;
    if (stream_chk) begin
      if (hk[1]) begin
        chk("frame_start", 32'(frame_start), 32'(hfs[1]));
        if (hval[1]) begin
          chk("scan_addr", 32'(mem_addr), 32'(addr_of(hh[1], hv[1])));
          chk("scan_we", 32'(mem_we), 32'd0);
        end
      end
      if (hk[3]) begin
        chk("pix_valid", 32'(pix_valid), 32'(hval[3]));
        chk("hsync_d", 32'(H_Sync_d), 32'(hhs[3]));
        chk("vsync_d", 32'(V_Sync_d), 32'(hvs[3]));
        chk("rgb_out", 32'(rgb_out), hval[3] ? 32'(exp_mem[addr_of(hh[3], hv[3])]) : 32'd0);
      end
    end
  endtask

  // Blanking write of one word: expect mem_we (if in range) then wr_ack.
  task automatic blank_write(input int addr, input int data, input int h0, input int v, input bit exp_we);
    wr_addr = 13'(addr);
    wr_data = 12'(data);
    wr_req  = 1'b1;
    for (int h = h0; h < h0 + 6; h++) begin
      if (h >= h0 + 2) wr_req = 1'b0;
      drive(h, v);
      step();
      chk("blank_we", 32'(mem_we), 32'(exp_we && (h == h0)));
      chk("blank_ack", 32'(wr_ack), 32'(h == h0 + 1));
      if (exp_we && h == h0) chk("blank_addr", 32'(mem_addr), 32'(addr));
    end
    if (exp_we) exp_mem[addr] = data;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) exp_mem[i] = i % 4096;

    // Reset held for 5 cycles with the counter mid-frame.
    resetM = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(100 + i, 100);
      step();
    end
    chk("rst_wr_ack", 32'(wr_ack), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_rgb_out", 32'(rgb_out), 32'd0);
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_hsync_d", 32'(H_Sync_d), 32'd0);
    chk("rst_vsync_d", 32'(V_Sync_d), 32'd0);
    chk("rst_frame_start", 32'(frame_start), 32'd0);

    // First active sample after release appears three cycles later.
    clear_hist();
    resetM = 1'b1;
    stream_chk = 1'b1;
    drive(200, 40); step();
    chk("post_rst_addr", 32'(mem_addr), 32'd425);
    drive(201, 40); step();
    chk("post_rst_rgb_early", 32'(rgb_out), 32'd0);
    drive(202, 40); step();
    chk("post_rst_rgb", 32'(rgb_out), 32'd425);

    // Scan address at Qh=17, Qv=9.
    drive(17, 9); step();
    chk("addr_17_9", 32'(mem_addr), 32'd82);
    drive(18, 9); step();
    drive(19, 9); step();
    chk("rgb_17_9", 32'(rgb_out), 32'd82);

    // Write in blanking at Qh=650.
    wr_addr = 13'd100; wr_data = 12'hABC; wr_req = 1'b1;
    drive(650, 8); step();
    chk("wr_we", 32'(mem_we), 32'd1);
    chk("wr_addr", 32'(mem_addr), 32'd100);
    chk("wr_wdata", 32'(mem_wdata), 32'hABC);
    chk("wr_ack_early", 32'(wr_ack), 32'd0);
    drive(651, 8); step();
    chk("wr_ack", 32'(wr_ack), 32'd1);
    chk("wr_we_after", 32'(mem_we), 32'd0);
    exp_mem[100] = 32'hABC;
    wr_req = 1'b0;
    drive(652, 8); step();
    chk("wr_ack_late", 32'(wr_ack), 32'd0);
    drive(653, 8); step();
    drive(160, 8); step();
    chk("readback_addr", 32'(mem_addr), 32'd100);
    drive(161, 8); step();
    drive(162, 8); step();
    chk("readback_rgb", 32'(rgb_out), 32'hABC);

    // Request raised during active video waits for the first blank sample.
    wr_addr = 13'd200; wr_data = 12'h5A5; wr_req = 1'b1;
    for (int h = 100; h <= 645; h++) begin
      if (h >= 642) wr_req = 1'b0;
      drive(h, 16);
      step();
      chk("active_we", 32'(mem_we), 32'(h == 640));
      chk("active_ack", 32'(wr_ack), 32'(h == 641));
      if (h == 640) begin
        chk("active_wr_addr", 32'(mem_addr), 32'd200);
        chk("active_wr_data", 32'(mem_wdata), 32'h5A5);
      end
    end
    exp_mem[200] = 32'h5A5;
    drive(320, 17); step();
    drive(321, 17); step();
    drive(322, 17); step();
    chk("active_readback", 32'(rgb_out), 32'h5A5);

    // Range boundary: 5000 and 4800 suppressed, 4799 written.
    blank_write(5000, 12'hEEE, 700, 20, 1'b0);
    chk("ram_5000_kept", 32'(ram[5000]), 32'd904);
    blank_write(4800, 12'hDDD, 710, 20, 1'b0);
    chk("ram_4800_kept", 32'(ram[4800]), 32'd704);
    blank_write(4799, 12'h123, 720, 20, 1'b1);

    // Reset in the middle of a handshake aborts the write with no ack.
    wr_addr = 13'd300; wr_data = 12'hFFF; wr_req = 1'b1;
    drive(700, 24); step();
    chk("abort_we_before", 32'(mem_we), 32'd1);
    #2;
    resetM = 1'b0;
    stream_chk = 1'b0;
    wr_req = 1'b0;
    #1;
    chk("abort_async_we", 32'(mem_we), 32'd0);
    chk("abort_async_addr", 32'(mem_addr), 32'd0);
    chk("abort_async_ack", 32'(wr_ack), 32'd0);
    drive(701, 24); step();
    chk("abort_ack_rst", 32'(wr_ack), 32'd0);
    drive(702, 24); step();
    clear_hist();
    resetM = 1'b1;
    stream_chk = 1'b1;
    for (int h = 703; h < 707; h++) begin
      drive(h, 24); step();
      chk("abort_ack_after", 32'(wr_ack), 32'd0);
      chk("abort_we_after", 32'(mem_we), 32'd0);
    end
    chk("ram_300_kept", 32'(ram[300]), 32'd300);

    // Full frame (8-pixel horizontal stride) with a stalled origin, then wrap.
    fs_count = 0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0); step();
    end
    for (int v = 0; v < 525; v++) begin
      for (int h = 0; h < 800; h += 8) begin
        drive(h, v); step();
      end
    end
    chk("frame_pulses", 32'(fs_count), 32'd1);
    drive(0, 0); step();
    chk("wrap_frame_start", 32'(frame_start), 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive(8 * (i + 1), 0); step();
    end
    chk("frame_pulses_wrap", 32'(fs_count), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
